// File: rtl/spi_read.sv
// SPI_READ: reads 1..4 bytes from an ILI9341-style panel over SPI mode 0.
// A read sends one command byte (D/CX low), an optional dummy SCLK period,
// and then shifts in the data bytes, first byte most significant.
module spi_read #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read_ena,
    input  logic [7:0]  i_cmd,
    input  logic [2:0]  i_nbytes,
    input  logic        i_dummy,
    input  logic        i_miso,
    output logic        o_cs_n,
    output logic        o_sclk,
    output logic        o_dc,
    output logic        o_mosi,
    output logic        o_busy,
    output logic        o_read_done,
    output logic [31:0] o_data
);

    localparam int HCW = $clog2(CLK_DIV + 1);
    localparam logic [HCW-1:0] HALF_RELOAD = HCW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        CMD   = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4,
        HOLD  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [HCW-1:0]  halfCnt_q, halfCnt_d;
    logic            phase_q, phase_d;
    logic [5:0]      bitCnt_q, bitCnt_d;
    logic [7:0]      cmdShift_q, cmdShift_d;
    logic [2:0]      nbytes_q, nbytes_d;
    logic            dummy_q, dummy_d;
    logic [31:0]     data_q, data_d;
    logic [5:0]      dataBitsLast;

    // A byte count of 0 means one byte; anything above 4 is limited to 4.
    function automatic logic [2:0] clampBytes(input logic [2:0] n);
        logic [2:0] r;
        if (n == 3'd0) begin
            r = 3'd1;
        end else if (n > 3'd4) begin
            r = 3'd4;
        end else begin
            r = n;
        end
        return r;
    endfunction

    // Index of the last data bit period (8N-1), used to load the bit counter.
    assign dataBitsLast = {nbytes_q, 3'b000} - 6'd1;

    // State and datapath registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            halfCnt_q  <= '0;
            phase_q    <= 1'b0;
            bitCnt_q   <= '0;
            cmdShift_q <= '0;
            nbytes_q   <= 3'd1;
            dummy_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            halfCnt_q  <= halfCnt_d;
            phase_q    <= phase_d;
            bitCnt_q   <= bitCnt_d;
            cmdShift_q <= cmdShift_d;
            nbytes_q   <= nbytes_d;
            dummy_q    <= dummy_d;
            data_q     <= data_d;
        end
    end

    // Next-state logic: half-period timing, bit counting and shift registers.
    always_comb begin
        state_d    = state_q;
        halfCnt_d  = halfCnt_q;
        phase_d    = phase_q;
        bitCnt_d   = bitCnt_q;
        cmdShift_d = cmdShift_q;
        nbytes_d   = nbytes_q;
        dummy_d    = dummy_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                if (i_read_ena) begin
                    state_d    = SETUP;
                    cmdShift_d = i_cmd;
                    nbytes_d   = clampBytes(i_nbytes);
                    dummy_d    = i_dummy;
                    data_d     = '0;
                    halfCnt_d  = HALF_RELOAD;
                    phase_d    = 1'b0;
                    bitCnt_d   = '0;
                end
            end

            SETUP: begin
                if (halfCnt_q == '0) begin
                    state_d   = CMD;
                    halfCnt_d = HALF_RELOAD;
                    phase_d   = 1'b0;
                    bitCnt_d  = 6'd7;
                end else begin
                    halfCnt_d = halfCnt_q - 1'b1;
                end
            end

            CMD, DUMMY, DATA: begin
                if (halfCnt_q != '0) begin
                    halfCnt_d = halfCnt_q - 1'b1;
                end else begin
                    halfCnt_d = HALF_RELOAD;
                    if (!phase_q) begin
                        // End of the low half: SCLK rises and MISO is sampled.
                        phase_d = 1'b1;
                        if (state_q == DATA) begin
                            data_d = {data_q[30:0], i_miso};
                        end
                    end else begin
                        // End of the high half: SCLK falls and a new bit begins.
                        phase_d = 1'b0;
                        if (bitCnt_q != '0) begin
                            bitCnt_d = bitCnt_q - 6'd1;
                            if (state_q == CMD) begin
                                cmdShift_d = {cmdShift_q[6:0], 1'b0};
                            end
                        end else begin
                            case (state_q)
                                CMD: begin
                                    if (dummy_q) begin
                                        state_d  = DUMMY;
                                        bitCnt_d = '0;
                                    end else begin
                                        state_d  = DATA;
                                        bitCnt_d = dataBitsLast;
                                    end
                                end
                                DUMMY: begin
                                    state_d  = DATA;
                                    bitCnt_d = dataBitsLast;
                                end
                                default: begin
                                    state_d  = HOLD;
                                    bitCnt_d = '0;
                                end
                            endcase
                        end
                    end
                end
            end

            HOLD: begin
                if (halfCnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    halfCnt_d = halfCnt_q - 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the registered state, so reset forces idle levels at once.
    always_comb begin
        o_cs_n      = 1'b1;
        o_sclk      = 1'b0;
        o_dc        = 1'b1;
        o_mosi      = 1'b0;
        o_busy      = 1'b0;
        o_read_done = 1'b0;

        case (state_q)
            SETUP: begin
                o_cs_n = 1'b0;
                o_busy = 1'b1;
                o_mosi = cmdShift_q[7];
            end
            CMD: begin
                o_cs_n = 1'b0;
                o_busy = 1'b1;
                o_dc   = 1'b0;
                o_sclk = phase_q;
                o_mosi = cmdShift_q[7];
            end
            DUMMY, DATA: begin
                o_cs_n = 1'b0;
                o_busy = 1'b1;
                o_sclk = phase_q;
            end
            HOLD: begin
                o_cs_n = 1'b0;
                o_busy = 1'b1;
            end
            DONE: begin
                o_busy      = 1'b1;
                o_read_done = 1'b1;
            end
            default: begin
                o_cs_n = 1'b1;
            end
        endcase
    end

    assign o_data = data_q;

endmodule

// File: tb/tb_spi_read.sv
// Self-checking bench for spi_read with a bit-stream panel model.
module tb_spi_read;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_read_ena = 1'b0;
    logic [7:0]  i_cmd = 8'h00;
    logic [2:0]  i_nbytes = 3'd0;
    logic        i_dummy = 1'b0;
    logic        i_miso;
    logic        o_cs_n, o_sclk, o_dc, o_mosi, o_busy, o_read_done;
    logic [31:0] o_data;

    int vectors = 0;
    int miscompares = 0;

    // Panel model: the bit presented on MISO before each SCLK rising edge.
    logic [63:0] misoBits = '0;
    int          bitIdx = 0;
    logic        prevCs = 1'b1;
    logic        prevSclk = 1'b0;
    int          riseCount = 0;
    int          csFalls = 0;
    int          dcLowRises = 0;
    logic [7:0]  cmdCapture = 8'h00;
    int          doneCount = 0;

    spi_read #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .i_read_ena(i_read_ena), .i_cmd(i_cmd),
        .i_nbytes(i_nbytes), .i_dummy(i_dummy), .i_miso(i_miso),
        .o_cs_n(o_cs_n), .o_sclk(o_sclk), .o_dc(o_dc), .o_mosi(o_mosi),
        .o_busy(o_busy), .o_read_done(o_read_done), .o_data(o_data)
    );

    always #5 clk = ~clk;

    assign i_miso = misoBits[bitIdx[5:0]];

    // Panel side: restart the stream on CS fall, advance on SCLK fall,
    // and record the command bits seen on MOSI while D/CX is low.
    always @(o_cs_n or o_sclk) begin
        if (prevCs === 1'b1 && o_cs_n === 1'b0) begin
            csFalls++;
            bitIdx = 0;
        end
        if (prevSclk === 1'b0 && o_sclk === 1'b1) begin
            riseCount++;
            if (o_dc === 1'b0) begin
                dcLowRises++;
                cmdCapture = {cmdCapture[6:0], o_mosi};
            end
        end
        if (prevSclk === 1'b1 && o_sclk === 1'b0) begin
            bitIdx++;
        end
        prevCs = o_cs_n;
        prevSclk = o_sclk;
    end

    // Counts done pulses away from the active edge.
    always @(negedge clk) begin
        if (o_read_done === 1'b1) doneCount++;
    end

    // Reference model: effective byte count, latency and right-aligned data.
    function automatic int modelN(input logic [2:0] nb);
        if (nb == 3'd0) return 1;
        if (nb > 3'd4) return 4;
        return int'(nb);
    endfunction

    function automatic int modelLatency(input logic [2:0] nb, input logic d);
        return 2 * CLK_DIV * (9 + int'(d) + 8 * modelN(nb));
    endfunction

    function automatic logic [31:0] modelData(input logic [31:0] bytesMsbFirst, input logic [2:0] nb);
        int n;
        n = modelN(nb);
        return bytesMsbFirst >> (32 - 8 * n);
    endfunction

    // Loads the panel stream: junk during command/dummy, then the data bytes.
    task automatic loadPanel(input logic [31:0] bytesMsbFirst, input logic [2:0] nb, input logic d);
        int n;
        n = modelN(nb);
        for (int i = 0; i < 64; i++) misoBits[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8 * n; i++) misoBits[8 + int'(d) + i] = bytesMsbFirst[31 - i];
    endtask

    // Runs one read and returns what was observed; optionally pulses a start during DATA.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [2:0] nb, input logic d,
                                 input logic [31:0] bytesMsbFirst, input logic pulseBusy,
                                 output int latency, output logic [31:0] dataAtDone,
                                 output int rises, output int dcRises, output int csCount);
        int startRise, startDc, startCs, cycle, pulseAt;
        loadPanel(bytesMsbFirst, nb, d);
        startRise = riseCount;
        startDc = dcLowRises;
        startCs = csFalls;
        pulseAt = CLK_DIV * (1 + 16 + 2 * int'(d)) + 5;
        @(negedge clk);
        i_read_ena = 1'b1;
        i_cmd = cmd;
        i_nbytes = nb;
        i_dummy = d;
        @(posedge clk);
        @(negedge clk);
        i_read_ena = 1'b0;
        i_cmd = 8'($urandom);
        i_nbytes = 3'($urandom);
        i_dummy = 1'($urandom);
        latency = -1;
        dataAtDone = '0;
        cycle = 0;
        while (cycle < 2000) begin
            if (o_read_done === 1'b1) begin
                latency = cycle;
                dataAtDone = o_data;
                break;
            end
            if (pulseBusy && cycle == pulseAt) begin
                i_read_ena = 1'b1;
                i_cmd = 8'hFF;
            end else begin
                i_read_ena = 1'b0;
            end
            @(negedge clk);
            cycle++;
        end
        i_read_ena = 1'b0;
        @(negedge clk);
        rises = riseCount - startRise;
        dcRises = dcLowRises - startDc;
        csCount = csFalls - startCs;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (o_cs_n !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cs_n: got %b expected 1", o_cs_n); end
        vectors++; if (o_sclk !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sclk: got %b expected 0", o_sclk); end
        vectors++; if (o_dc !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_dc: got %b expected 1", o_dc); end
        vectors++; if (o_mosi !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mosi: got %b expected 0", o_mosi); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
        vectors++; if (o_read_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", o_read_done); end
        vectors++; if (o_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 0", o_data); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_after_reset_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_single_byte();
        int lat, rises, dcr, csc;
        logic [31:0] d;
        applyStimulus(8'h0A, 3'd1, 1'b0, 32'h9C000000, 1'b0, lat, d, rises, dcr, csc);
        vectors++; if (lat !== 68) begin miscompares++; $display("[TB] FAIL single_latency: got %0d expected 68", lat); end
        vectors++; if (d !== 32'h0000009C) begin miscompares++; $display("[TB] FAIL single_data: got %h expected 0000009c", d); end
        vectors++; if (cmdCapture !== 8'h0A) begin miscompares++; $display("[TB] FAIL single_mosi: got %h expected 0a", cmdCapture); end
        vectors++; if (dcr !== 8) begin miscompares++; $display("[TB] FAIL single_dc_low_bits: got %0d expected 8", dcr); end
        vectors++; if (rises !== 16) begin miscompares++; $display("[TB] FAIL single_sclk_rises: got %0d expected 16", rises); end
        repeat (5) @(negedge clk);
        vectors++; if (o_data !== 32'h0000009C) begin miscompares++; $display("[TB] FAIL single_data_hold: got %h expected 0000009c", o_data); end
        vectors++; if (o_cs_n !== 1'b1) begin miscompares++; $display("[TB] FAIL single_idle_cs_n: got %b expected 1", o_cs_n); end
    endtask

    task automatic test_display_id();
        int lat, rises, dcr, csc;
        logic [31:0] d;
        applyStimulus(8'h04, 3'd3, 1'b1, 32'h00934100, 1'b0, lat, d, rises, dcr, csc);
        vectors++; if (lat !== 136) begin miscompares++; $display("[TB] FAIL id_latency: got %0d expected 136", lat); end
        vectors++; if (d !== 32'h00009341) begin miscompares++; $display("[TB] FAIL id_data: got %h expected 00009341", d); end
        vectors++; if (rises !== 33) begin miscompares++; $display("[TB] FAIL id_sclk_rises: got %0d expected 33", rises); end
        vectors++; if (cmdCapture !== 8'h04) begin miscompares++; $display("[TB] FAIL id_mosi: got %h expected 04", cmdCapture); end
    endtask

    task automatic test_clamp();
        int lat, rises, dcr, csc;
        logic [31:0] d;
        applyStimulus(8'h09, 3'd0, 1'b0, 32'h5A000000, 1'b0, lat, d, rises, dcr, csc);
        vectors++; if (rises - 8 !== 8) begin miscompares++; $display("[TB] FAIL clampA_data_sclks: got %0d expected 8", rises - 8); end
        vectors++; if (d !== 32'h0000005A) begin miscompares++; $display("[TB] FAIL clampA_data: got %h expected 0000005a", d); end
        applyStimulus(8'h09, 3'd7, 1'b0, 32'h11223344, 1'b0, lat, d, rises, dcr, csc);
        vectors++; if (rises - 8 !== 32) begin miscompares++; $display("[TB] FAIL clampB_data_sclks: got %0d expected 32", rises - 8); end
        vectors++; if (d !== 32'h11223344) begin miscompares++; $display("[TB] FAIL clampB_data: got %h expected 11223344", d); end
        vectors++; if (lat !== modelLatency(3'd7, 1'b0)) begin miscompares++; $display("[TB] FAIL clampB_latency: got %0d expected %0d", lat, modelLatency(3'd7, 1'b0)); end
    endtask

    task automatic test_start_while_busy();
        int lat, rises, dcr, csc, startCs;
        logic [31:0] d;
        startCs = csFalls;
        applyStimulus(8'h09, 3'd2, 1'b0, 32'hC3A50000, 1'b1, lat, d, rises, dcr, csc);
        vectors++; if (d !== 32'h0000C3A5) begin miscompares++; $display("[TB] FAIL busy_data: got %h expected 0000c3a5", d); end
        vectors++; if (lat !== modelLatency(3'd2, 1'b0)) begin miscompares++; $display("[TB] FAIL busy_latency: got %0d expected %0d", lat, modelLatency(3'd2, 1'b0)); end
        vectors++; if (cmdCapture !== 8'h09) begin miscompares++; $display("[TB] FAIL busy_mosi: got %h expected 09", cmdCapture); end
        repeat (30) @(negedge clk);
        vectors++; if (csFalls - startCs !== 1) begin miscompares++; $display("[TB] FAIL busy_cs_assertions: got %0d expected 1", csFalls - startCs); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_idle_after: got %b expected 0", o_busy); end
    endtask

    task automatic test_reset_mid();
        int startDone, lat, rises, dcr, csc;
        logic [31:0] d;
        loadPanel(32'hF0A50000, 3'd2, 1'b0);
        startDone = doneCount;
        @(negedge clk);
        i_read_ena = 1'b1;
        i_cmd = 8'h0A;
        i_nbytes = 3'd2;
        i_dummy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_read_ena = 1'b0;
        repeat (51) @(negedge clk);
        vectors++; if (o_data !== 32'h0000000F) begin miscompares++; $display("[TB] FAIL midrst_partial_data: got %h expected 0000000f", o_data); end
        rst = 1'b0;
        #1;
        vectors++; if (o_cs_n !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_cs_n: got %b expected 1", o_cs_n); end
        vectors++; if (o_sclk !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_sclk: got %b expected 0", o_sclk); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy: got %b expected 0", o_busy); end
        vectors++; if (o_data !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_data: got %h expected 0", o_data); end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        vectors++; if (doneCount - startDone !== 0) begin miscompares++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", doneCount - startDone); end
        applyStimulus(8'h0A, 3'd2, 1'b0, 32'h5AA50000, 1'b0, lat, d, rises, dcr, csc);
        vectors++; if (d !== 32'h00005AA5) begin miscompares++; $display("[TB] FAIL midrst_after_data: got %h expected 00005aa5", d); end
        vectors++; if (lat !== modelLatency(3'd2, 1'b0)) begin miscompares++; $display("[TB] FAIL midrst_after_latency: got %0d expected %0d", lat, modelLatency(3'd2, 1'b0)); end
    endtask

    task automatic test_random();
        int lat, rises, dcr, csc;
        logic [31:0] d, bytesR;
        logic [7:0] cmd;
        logic [2:0] nb;
        logic dm;
        for (int it = 0; it < 10; it++) begin
            cmd = 8'($urandom);
            nb = 3'($urandom_range(0, 7));
            dm = 1'($urandom_range(0, 1));
            bytesR = $urandom;
            applyStimulus(cmd, nb, dm, bytesR, 1'b0, lat, d, rises, dcr, csc);
            vectors++; if (lat !== modelLatency(nb, dm)) begin miscompares++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, modelLatency(nb, dm)); end
            vectors++; if (d !== modelData(bytesR, nb)) begin miscompares++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", it, d, modelData(bytesR, nb)); end
            vectors++; if (cmdCapture !== cmd) begin miscompares++; $display("[TB] FAIL rand_mosi[%0d]: got %h expected %h", it, cmdCapture, cmd); end
            vectors++; if (rises !== 8 + int'(dm) + 8 * modelN(nb)) begin miscompares++; $display("[TB] FAIL rand_sclk_rises[%0d]: got %0d expected %0d", it, rises, 8 + int'(dm) + 8 * modelN(nb)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_display_id();
        test_clamp();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_read.md
SPI_READ -- requirements
Module: spi_read

Interface
- REQ-001: Parameter CLK_DIV, default 4, clk cycles per SCLK half-period (legal range 1..255).
- REQ-002: clk  in  1  single clock; all state advances on its rising edge.
- REQ-003: rst  in  1  asynchronous, active-low reset.
- REQ-004: i_read_ena  in  1  start request, sampled only in IDLE.
- REQ-005: i_cmd  in  8  ILI9341 read command byte (e.g. 0x04, 0x09, 0x0A).
- REQ-006: i_nbytes  in  3  data bytes to read; 0 is treated as 1, 5..7 are clamped to 4.
- REQ-007: i_dummy  in  1  insert one dummy SCLK period between command and data.
- REQ-008: i_miso  in  1  serial data from the panel (SDO).
- REQ-009: o_cs_n  out  1  panel chip select, active-low.
- REQ-010: o_sclk  out  1  serial clock, SPI mode 0, idles low.
- REQ-011: o_dc  out  1  D/CX: low during the command byte, high otherwise.
- REQ-012: o_mosi  out  1  command bits, MSB first.
- REQ-013: o_busy  out  1  high while a transaction is in progress.
- REQ-014: o_read_done  out  1  one-cycle pulse at transaction end.
- REQ-015: o_data  out  32  received bytes, right-aligned.

Function
- REQ-016: FSM states IDLE, SETUP, CMD, DUMMY, DATA, HOLD, DONE; encodings outside these go to IDLE.
- REQ-017: In IDLE with i_read_ena=1, i_cmd, clamped i_nbytes and i_dummy are latched, o_data is cleared to 0, and the next state is SETUP. This edge is E0.
- REQ-018: i_read_ena is ignored in every state other than IDLE, with no queuing.
- REQ-019: In SETUP, o_cs_n=0, o_sclk=0 and o_mosi=i_cmd[7] for CLK_DIV cycles; the next state is CMD.
- REQ-020: Each bit period lasts 2*CLK_DIV cycles: o_sclk is 0 for the first CLK_DIV cycles and 1 for the next CLK_DIV cycles.
- REQ-021: o_mosi changes only while o_sclk=0.
- REQ-022: i_miso is sampled on the clk edge where o_sclk goes 0->1.
- REQ-023: CMD lasts 8 bit periods and shifts out i_cmd[7..0]; o_dc=0 only in this state.
- REQ-024: DUMMY (only if i_dummy=1) lasts 1 bit period; i_miso is not captured; o_mosi=0.
- REQ-025: DATA lasts 8*N bit periods.
  - Each sample shifts left into o_data[8N-1:0], MSB first, first byte most significant.
  - o_data[31:8N] stays 0; o_mosi=0.
- REQ-026: HOLD keeps o_cs_n=0 and o_sclk=0 for CLK_DIV cycles; the next state is DONE.
- REQ-027: DONE lasts 1 cycle with o_cs_n=1, o_read_done=1 and o_busy=1; the next state is IDLE.
- REQ-028: o_busy=1 in all states except IDLE.
- REQ-029: o_cs_n=1 and o_sclk=0 in IDLE and DONE.
- REQ-030: Latency: DONE occupies the cycle that starts 2*CLK_DIV*(9+D+8N) cycles after E0, where D=i_dummy and N=clamped byte count.
- REQ-031: o_data holds its value from DONE until the next accepted start.
- REQ-032: A new start is accepted at the earliest in the first IDLE cycle after DONE.
- REQ-033: The half-period counter is sized $clog2(CLK_DIV+1) bits and reloads at every phase change.
- REQ-034: The bit counter covers up to 32 bits and must not wrap during a transaction.

Reset
- REQ-035: While rst=0, all of the following hold immediately and asynchronously:
  - state=IDLE;
  - o_cs_n=1, o_sclk=0, o_dc=1, o_mosi=0;
  - o_busy=0, o_read_done=0, o_data=0.
- REQ-036: Reset asserted mid-transaction aborts it with no o_read_done pulse.
- REQ-037: After rst rises, the block waits in IDLE for i_read_ena.

Verification
- REQ-038: Single-byte read. CLK_DIV=2, i_cmd=0x0A, i_nbytes=1, i_dummy=0, panel model drives 0x9C.
  -> o_mosi carries 00001010 with o_dc=0; o_data=0x0000009C; o_read_done exactly 68 cycles after E0.
- REQ-039: Display ID read. i_cmd=0x04, i_nbytes=3, i_dummy=1, model drives 0x00,0x93,0x41.
  -> o_data=0x00009341; exactly 33 SCLK rising edges; DONE at 4*34=136 cycles after E0 (CLK_DIV=2).
- REQ-040: Count clamping. Case A: i_nbytes=0 with model byte 0x5A. Case B: i_nbytes=7 with model bytes 0x11,0x22,0x33,0x44.
  -> Case A gives 8 data SCLKs and o_data=0x0000005A; Case B gives 32 data SCLKs and o_data=0x11223344.
- REQ-041: Start while busy. Pulse i_read_ena with i_cmd=0xFF during DATA.
  -> The current transaction completes unchanged; no second CS_n assertion occurs until i_read_ena is pulsed again in IDLE.
- REQ-042: Reset mid-operation. Drive rst=0 in the 5th DATA bit.
  -> In the same cycle o_cs_n=1, o_sclk=0, o_busy=0, o_data=0; no o_read_done pulse; a read after rst rises completes normally.
